// File: rtl/life_pkg.sv
// Shared types and constants for the Life grid and its consumers.
//
// Contents:
//   GRID_ROWS / GRID_COLS : default grid geometry (8x8)
//   row_t                 : one grid row, bit c = cell[r][c]
//   grid_t                : flattened grid, bit r*GRID_COLS+c = cell[r][c]
//   state_t               : frame streamer states {IDLE, SEND}
//   row_of()              : extracts one row from a flattened grid
package life_pkg;

  localparam int GRID_ROWS = 8;
  localparam int GRID_COLS = 8;

  typedef logic [GRID_COLS-1:0]           row_t;
  typedef logic [GRID_ROWS*GRID_COLS-1:0] grid_t;

  typedef enum logic {IDLE, SEND} state_t;

  function automatic row_t row_of(input grid_t grid, input int unsigned idx);
    return grid[idx*GRID_COLS +: GRID_COLS];
  endfunction

endpackage

// File: rtl/life_popcount.sv
// Combinational population count over a flattened cell grid.
// Shared by the frame streamer (per-frame live count) and the matrix
// (extinction check).
//
// Parameters:
//   N      : number of input bits (defaults to the full grid)
// Ports:
//   bits   in  N                live cell bits
//   count  out $clog2(N+1)      number of set bits; wide enough that N does
//                               not wrap
module life_popcount
  import life_pkg::*;
#(
  parameter int N = GRID_ROWS * GRID_COLS
) (
  input  logic [N-1:0]             bits,
  output logic [$clog2(N+1)-1:0]   count
);

  localparam int CW = $clog2(N + 1);

  // Written as a running sum; synthesis rebalances it into an adder tree.
  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/life_frame_streamer.sv
// Snapshots the Life grid on every generation tick and streams it out one
// row per beat over a valid/ready interface. A single pending snapshot
// absorbs ticks that arrive while a frame is in flight; when a second tick
// lands on an occupied pending slot the newest grid wins and the dropped
// frame counter saturates upward.
//
// Optional feature (macro LIFE_STABLE_DETECT_EN): adds out_stable, which is
// high on every beat of a frame identical to the previously completed frame.
//
// Ports:
//   clk        in   system clock, rising edge
//   _rst       in   asynchronous reset, active-high
//   grid_in    in   live cells, bit r*COLS+c = cell[r][c]
//   gen_tick   in   one-cycle pulse, grid_in holds a new generation
//   out_valid  out  beat valid
//   out_ready  in   sink accepts a beat when out_valid & out_ready
//   out_data   out  row bits, bit c = cell[out_row][c]
//   out_row    out  row index of the current beat
//   out_sof    out  high on the row-0 beat
//   out_eof    out  high on the last-row beat
//   pop_count  out  live-cell count of the frame being streamed
//   drop_cnt   out  saturating count of overwritten pending snapshots
//   out_stable out  (LIFE_STABLE_DETECT_EN only) frame equals previous frame
//   busy       out  frame in flight or snapshot pending
module life_frame_streamer
  import life_pkg::*;
#(
  parameter int ROWS   = GRID_ROWS,
  parameter int COLS   = GRID_COLS,
  parameter int DROP_W = 8
) (
  input  logic                            clk,
  input  logic                            _rst,
  input  logic [ROWS*COLS-1:0]            grid_in,
  input  logic                            gen_tick,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [COLS-1:0]                 out_data,
  output logic [$clog2(ROWS)-1:0]         out_row,
  output logic                            out_sof,
  output logic                            out_eof,
  output logic [$clog2(ROWS*COLS+1)-1:0]  pop_count,
  output logic [DROP_W-1:0]               drop_cnt,
`ifdef LIFE_STABLE_DETECT_EN
  output logic                            out_stable,
`endif
  output logic                            busy
);

  localparam int N     = ROWS * COLS;
  localparam int ROW_W = $clog2(ROWS);
  localparam int POP_W = $clog2(N + 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [N-1:0]       cur_buf_q, cur_buf_d;
  logic [POP_W-1:0]   cur_pop_q, cur_pop_d;
  logic [N-1:0]       pend_buf_q, pend_buf_d;
  logic [POP_W-1:0]   pend_pop_q, pend_pop_d;
  logic               pend_v_q, pend_v_d;
  logic [DROP_W-1:0]  drop_q, drop_d;

  logic [POP_W-1:0]   grid_pop;
  logic               handshake;
  logic               last_beat;

  life_popcount #(.N(N)) u_popcount (
    .bits  (grid_in),
    .count (grid_pop)
  );

  assign handshake = (state_q == SEND) && out_ready;
  assign last_beat = handshake && (row_q == LAST_ROW);

  always_ff @(posedge clk or posedge _rst) begin
    if (_rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      cur_buf_q  <= '0;
      cur_pop_q  <= '0;
      pend_buf_q <= '0;
      pend_pop_q <= '0;
      pend_v_q   <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      cur_buf_q  <= cur_buf_d;
      cur_pop_q  <= cur_pop_d;
      pend_buf_q <= pend_buf_d;
      pend_pop_q <= pend_pop_d;
      pend_v_q   <= pend_v_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cur_buf_d  = cur_buf_q;
    cur_pop_d  = cur_pop_q;
    pend_buf_d = pend_buf_q;
    pend_pop_d = pend_pop_q;
    pend_v_d   = pend_v_q;
    drop_d     = drop_q;

    case (state_q)
      IDLE: begin
        if (gen_tick) begin
          cur_buf_d = grid_in;
          cur_pop_d = grid_pop;
          row_d     = '0;
          state_d   = SEND;
        end
      end

      SEND: begin
        if (last_beat) begin
          row_d = '0;
          // The pending slot drains first, so a coincident tick refills it
          // rather than colliding with the old snapshot: no drop here.
          if (pend_v_q) begin
            cur_buf_d = pend_buf_q;
            cur_pop_d = pend_pop_q;
            if (gen_tick) begin
              pend_buf_d = grid_in;
              pend_pop_d = grid_pop;
            end else begin
              pend_v_d = 1'b0;
            end
          end else if (gen_tick) begin
            cur_buf_d = grid_in;
            cur_pop_d = grid_pop;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (handshake) begin
            row_d = row_q + 1'b1;
          end
          if (gen_tick) begin
            pend_buf_d = grid_in;
            pend_pop_d = grid_pop;
            pend_v_d   = 1'b1;
            if (pend_v_q && (drop_q != '1)) begin
              drop_d = drop_q + 1'b1;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state_q == SEND);
  assign out_data  = out_valid ? cur_buf_q[int'(row_q)*COLS +: COLS] : '0;
  assign out_row   = row_q;
  assign out_sof   = out_valid && (row_q == '0);
  assign out_eof   = out_valid && (row_q == LAST_ROW);
  assign pop_count = cur_pop_q;
  assign drop_cnt  = drop_q;
  assign busy      = out_valid || pend_v_q;

`ifdef LIFE_STABLE_DETECT_EN
  logic [N-1:0] prev_buf_q, prev_buf_d;
  logic         prev_v_q, prev_v_d;

  always_ff @(posedge clk or posedge _rst) begin
    if (_rst) begin
      prev_buf_q <= '0;
      prev_v_q   <= 1'b0;
    end else begin
      prev_buf_q <= prev_buf_d;
      prev_v_q   <= prev_v_d;
    end
  end

  // The reference frame only advances once the sink has taken the eof
  // beat, so a frame aborted by reset never becomes the comparison basis.
  always_comb begin
    prev_buf_d = prev_buf_q;
    prev_v_d   = prev_v_q;
    if (last_beat) begin
      prev_buf_d = cur_buf_q;
      prev_v_d   = 1'b1;
    end
  end

  assign out_stable = out_valid && prev_v_q && (cur_buf_q == prev_buf_q);
`endif

endmodule

// File: tb/tb_life_frame_streamer.sv
// Self-checking bench for life_frame_streamer (8x8 grid, 8-bit drop count).
// A frame-level model (one frame in flight plus a one-deep wait queue)
// predicts every output on every cycle; directed scenarios add literal
// expectations on the logged beats.
module tb_life_frame_streamer;

  logic        clk;
  logic        rst;
  logic [63:0] grid_in;
  logic        gen_tick;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_row;
  logic        out_sof;
  logic        out_eof;
  logic [6:0]  pop_count;
  logic [7:0]  drop_cnt;
  logic        out_stable;
  logic        busy;

  life_frame_streamer dut (
    .clk       (clk),
    ._rst      (rst),
    .grid_in   (grid_in),
    .gen_tick  (gen_tick),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .pop_count (pop_count),
    .drop_cnt  (drop_cnt),
`ifdef LIFE_STABLE_DETECT_EN
    .out_stable(out_stable),
`endif
    .busy      (busy)
  );

`ifndef LIFE_STABLE_DETECT_EN
  assign out_stable = 1'b0;
`endif

  typedef struct {
    int          row;
    logic [7:0]  data;
    logic        sof;
    logic        eof;
    int          pop;
    logic        stable;
    int          cyc;
  } beat_t;

  int    n_vec = 0;
  int    n_err = 0;
  int    cyc   = 0;
  beat_t beats[$];

  // Frame-level model state
  logic        m_sending;
  logic [63:0] m_cur;
  int          m_beat;
  logic [63:0] m_wait[$];
  int          m_drop;
  logic        m_have_last;
  logic [63:0] m_last;
  logic        m_done;

  // Scenario data
  logic [63:0] g_blinker, g_pat, g_a, g_b, g_c, g_block, g_ones, g_zero;
  int          tick_cyc;
  int          pos;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [63:0] g, input logic t, input logic r);
    @(posedge clk);
    #1;
    grid_in   = g;
    gen_tick  = t;
    out_ready = r;
  endtask

  // Model: a frame finishes when its last row is accepted, then the waiting
  // frame (if any) takes over; a tick either starts a frame, fills the empty
  // wait slot, or replaces the waiting frame and counts a drop.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sending   = 1'b0;
      m_cur       = '0;
      m_beat      = 0;
      m_wait.delete();
      m_drop      = 0;
      m_have_last = 1'b0;
      m_last      = '0;
    end else begin
      m_done = 1'b0;
      if (m_sending && out_ready) begin
        if (m_beat == 7) m_done = 1'b1;
        else m_beat++;
      end
      if (m_done) begin
        m_last      = m_cur;
        m_have_last = 1'b1;
        if (m_wait.size() > 0) begin
          m_cur  = m_wait.pop_front();
          m_beat = 0;
        end else begin
          m_sending = 1'b0;
        end
      end
      if (gen_tick) begin
        if (!m_sending) begin
          m_cur     = grid_in;
          m_beat    = 0;
          m_sending = 1'b1;
        end else if (m_wait.size() > 0) begin
          m_wait[0] = grid_in;
          if (m_drop < 255) m_drop++;
        end else begin
          m_wait.push_back(grid_in);
        end
      end
    end
  end

  // Per-cycle compare against the model, plus a log of accepted beats.
  always @(negedge clk) begin
    if (!rst) begin
      check_output("valid", out_valid, m_sending);
      check_output("busy", busy, m_sending || (m_wait.size() > 0));
      check_output("drop_cnt", drop_cnt, m_drop);
      if (m_sending) begin
        check_output("data", out_data, m_cur[m_beat*8 +: 8]);
        check_output("row", out_row, m_beat);
        check_output("sof", out_sof, m_beat == 0);
        check_output("eof", out_eof, m_beat == 7);
        check_output("pop", pop_count, $countones(m_cur));
`ifdef LIFE_STABLE_DETECT_EN
        check_output("stable", out_stable, m_have_last && (m_cur == m_last));
`endif
      end
      if (out_valid && out_ready) begin
        beats.push_back('{row: int'(out_row), data: out_data, sof: out_sof, eof: out_eof,
                          pop: int'(pop_count), stable: out_stable, cyc: cyc});
      end
    end
  end

  initial begin
    g_blinker = 64'h0000_0000_0038_0000;
    g_pat     = 64'h0123_4567_89AB_CDEF;
    g_a       = 64'h1111_2222_3333_4444;
    g_b       = 64'h5555_6666_7777_8888;
    g_c       = 64'h99AA_BBCC_DDEE_FF00;
    g_block   = 64'h0000_0018_1800_0000;
    g_ones    = '1;
    g_zero    = '0;

    rst = 1'b1; grid_in = '0; gen_tick = 1'b0; out_ready = 1'b0;
    #3;
    check_output("rst_valid", out_valid, 1'b0);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_drop", drop_cnt, 8'd0);
    check_output("rst_pop", pop_count, 7'd0);
    check_output("rst_data", out_data, 8'd0);
    check_output("rst_sof", out_sof, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Blinker, sink always ready
    beats.delete();
    apply_stimulus(g_blinker, 1'b1, 1'b1);
    tick_cyc = cyc;
    repeat (10) apply_stimulus(g_zero, 1'b0, 1'b1);
    check_output("blinker_beats", beats.size(), 8);
    check_output("blinker_latency", beats[0].cyc, tick_cyc + 1);
    check_output("blinker_span", beats[7].cyc - beats[0].cyc, 7);
    check_output("blinker_row2", beats[2].data, 8'b0011_1000);
    check_output("blinker_row3", beats[3].data, 8'h00);
    check_output("blinker_sof", beats[0].sof, 1'b1);
    check_output("blinker_eof", beats[7].eof, 1'b1);
    check_output("blinker_pop", beats[0].pop, 3);

    // Stalling sink, ready pattern 1,0,0,1
    beats.delete();
    apply_stimulus(g_pat, 1'b1, 1'b0);
    for (int i = 0; i < 36; i++) begin
      apply_stimulus(g_zero, 1'b0, (i % 4 == 0) || (i % 4 == 3));
    end
    check_output("stall_beats", beats.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check_output("stall_row_order", beats[i].row, i);
      check_output("stall_row_data", beats[i].data, g_pat[i*8 +: 8]);
    end

    // A, then B and C during A: B dropped, C follows A with no bubble
    beats.delete();
    apply_stimulus(g_a, 1'b1, 1'b1);
    apply_stimulus(g_zero, 1'b0, 1'b1);
    apply_stimulus(g_b, 1'b1, 1'b1);
    apply_stimulus(g_zero, 1'b0, 1'b1);
    apply_stimulus(g_c, 1'b1, 1'b1);
    repeat (16) apply_stimulus(g_zero, 1'b0, 1'b1);
    check_output("abc_beats", beats.size(), 16);
    check_output("abc_a_row0", beats[0].data, 8'h44);
    check_output("abc_c_row0", beats[8].data, 8'h00);
    check_output("abc_c_row7", beats[15].data, 8'h99);
    check_output("abc_c_sof", beats[8].sof, 1'b1);
    check_output("abc_no_bubble", beats[8].cyc - beats[7].cyc, 1);
    check_output("abc_drop", drop_cnt, 8'd1);

    // All ones then all zeros
    beats.delete();
    apply_stimulus(g_ones, 1'b1, 1'b1);
    repeat (9) apply_stimulus(g_zero, 1'b0, 1'b1);
    apply_stimulus(g_zero, 1'b1, 1'b1);
    repeat (9) apply_stimulus(g_zero, 1'b0, 1'b1);
    check_output("ones_zero_beats", beats.size(), 16);
    check_output("ones_pop", beats[0].pop, 64);
    check_output("ones_row5", beats[5].data, 8'hFF);
    check_output("zero_pop", beats[8].pop, 0);
    check_output("zero_row5", beats[13].data, 8'h00);

    // Saturating drop counter: stalled frame, a tick every cycle
    apply_stimulus(g_pat, 1'b1, 1'b0);
    for (int i = 0; i < 260; i++) begin
      apply_stimulus({$urandom, $urandom}, 1'b1, 1'b0);
    end
    apply_stimulus(g_zero, 1'b0, 1'b0);
    #1 check_output("drop_saturated", drop_cnt, 8'hFF);
    repeat (20) apply_stimulus(g_zero, 1'b0, 1'b1);

    // Reset in the middle of a frame, at row 4
    apply_stimulus(g_pat, 1'b1, 1'b1);
    repeat (5) apply_stimulus(g_zero, 1'b0, 1'b1);
    check_output("mid_row", out_row, 3'd4);
    rst = 1'b1;
    #1;
    check_output("mid_rst_valid", out_valid, 1'b0);
    check_output("mid_rst_drop", drop_cnt, 8'd0);
    check_output("mid_rst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    beats.delete();
    apply_stimulus(g_blinker, 1'b1, 1'b1);
    repeat (10) apply_stimulus(g_zero, 1'b0, 1'b1);
    check_output("restart_beats", beats.size(), 8);
    check_output("restart_row0", beats[0].row, 0);
    check_output("restart_row2", beats[2].data, 8'h38);

`ifdef LIFE_STABLE_DETECT_EN
    // 2x2 block still life ticked twice after a fresh reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    beats.delete();
    apply_stimulus(g_block, 1'b1, 1'b1);
    repeat (10) apply_stimulus(g_zero, 1'b0, 1'b1);
    apply_stimulus(g_block, 1'b1, 1'b1);
    repeat (10) apply_stimulus(g_zero, 1'b0, 1'b1);
    check_output("block_beats", beats.size(), 16);
    for (int i = 0; i < 8; i++) begin
      check_output("block_frame1_stable", beats[i].stable, 1'b0);
      check_output("block_frame2_stable", beats[8+i].stable, 1'b1);
    end
    check_output("block_row3", beats[3].data, 8'h18);
`endif

    repeat (2) apply_stimulus(g_zero, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
